// File: rtl/apb_multi_monitor.sv
// Passive APB3/APB4 protocol monitor for one master fanning out to NS slaves.
// Reports sticky violation flags, first-error capture, completed-transfer count and worst stall.
module apb_multi_monitor #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NS         = 4,
    parameter int MAXSTALL   = 16,
    parameter int OPT_SLVERR = 1,
    parameter int OPT_APB4   = 1,
    parameter int CW         = 32,
    localparam int SW        = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [NS-1:0]   PSEL,
    input  logic            PENABLE,
    input  logic [AW-1:0]   PADDR,
    input  logic            PWRITE,
    input  logic [DW-1:0]   PWDATA,
    input  logic [DW/8-1:0] PSTRB,
    input  logic [2:0]      PPROT,
    input  logic [NS-1:0]   PREADY,
    input  logic [NS-1:0]   PSLVERR,
    input  logic            i_clear,
    output logic [7:0]      o_err_flags,
    output logic            o_err_valid,
    output logic [7:0]      o_first_flags,
    output logic [AW-1:0]   o_first_addr,
    output logic [SW-1:0]   o_first_sel,
    output logic [CW-1:0]   o_txn_count,
    output logic [CW-1:0]   o_stall_max
);

    localparam int SB = DW / 8;
    // With the timeout disabled the stall counter still runs, saturating at all-ones.
    localparam logic [CW-1:0] SCAP = (MAXSTALL == 0) ? {CW{1'b1}} : CW'(MAXSTALL);

    logic          sel, rdy, err, done, stalling;
    logic [SW-1:0] idx;
    logic          p_sel, p_en, p_rdy, p_write, p_done, in_stall;
    logic [SW-1:0] p_idx;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [SB-1:0] p_strb;
    logic [2:0]    p_prot;
    logic [CW-1:0] stall_cnt;
    logic [7:0]    det;

    always_comb begin
        idx = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (PSEL[i]) idx = SW'(i);
    end

    assign sel      = |PSEL;
    assign rdy      = PREADY[idx];
    assign err      = PSLVERR[idx];
    assign done     = sel & PENABLE & rdy;
    assign stalling = sel & PENABLE & ~rdy;
    assign p_done   = p_sel & p_en & p_rdy;
    assign in_stall = p_sel & ~p_done;

    always_comb begin
        det    = '0;
        det[0] = ~$onehot0(PSEL);
        det[1] = in_stall & (~sel | (idx != p_idx));
        det[2] = sel & ~p_sel & PENABLE;
        // After setup PENABLE must rise; after an access it must mirror !PREADY.
        det[3] = sel & p_sel & ((~p_en & ~PENABLE) | (p_en & (PENABLE != ~p_rdy)));
        det[4] = in_stall & ((PADDR != p_addr) | (PWRITE != p_write) | (PPROT != p_prot) |
                             (PWRITE & ((PWDATA != p_wdata) | (PSTRB != p_strb))));
        det[5] = (MAXSTALL != 0) & stalling & (stall_cnt == SCAP - 1'b1);
        det[6] = err & (~sel | ~PENABLE | ~rdy | (OPT_SLVERR == 0));
        det[7] = (OPT_APB4 != 0) & sel & ~PWRITE & (PSTRB != '0);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            p_sel         <= 1'b0;
            p_en          <= 1'b0;
            p_rdy         <= 1'b0;
            p_idx         <= '0;
            p_addr        <= '0;
            p_write       <= 1'b0;
            p_wdata       <= '0;
            p_strb        <= '0;
            p_prot        <= '0;
            stall_cnt     <= '0;
            o_err_flags   <= '0;
            o_err_valid   <= 1'b0;
            o_first_flags <= '0;
            o_first_addr  <= '0;
            o_first_sel   <= '0;
            o_txn_count   <= '0;
            o_stall_max   <= '0;
        end else begin
            p_sel   <= sel;
            p_en    <= PENABLE;
            p_rdy   <= rdy;
            p_idx   <= idx;
            p_addr  <= PADDR;
            p_write <= PWRITE;
            p_wdata <= PWDATA;
            p_strb  <= PSTRB;
            p_prot  <= PPROT;

            if (stalling) begin
                if (stall_cnt != SCAP) stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end

            // Events seen in the clear cycle survive the clear.
            if (i_clear) begin
                o_err_flags <= det;
                o_err_valid <= |det;
            end else begin
                o_err_flags <= o_err_flags | det;
                o_err_valid <= o_err_valid | (|det);
            end

            if ((i_clear | ~o_err_valid) & (|det)) begin
                o_first_flags <= det;
                o_first_addr  <= PADDR;
                o_first_sel   <= idx;
            end else if (i_clear) begin
                o_first_flags <= '0;
                o_first_addr  <= '0;
                o_first_sel   <= '0;
            end

            if (i_clear)
                o_txn_count <= {{(CW-1){1'b0}}, done};
            else if (done && (o_txn_count != {CW{1'b1}}))
                o_txn_count <= o_txn_count + 1'b1;

            if (~stalling && (i_clear || (stall_cnt > o_stall_max)))
                o_stall_max <= stall_cnt;
            else if (i_clear)
                o_stall_max <= '0;
        end
    end

endmodule

// File: tb/tb_apb_multi_monitor.sv
// Bench for apb_multi_monitor: directed scenarios plus randomized traffic against a cycle model.
module tb_apb_multi_monitor;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [3:0]  PREADY;
    logic [3:0]  PSLVERR;
    logic        i_clear;

    logic [7:0]  a_flags, b_flags, a_fflags, b_fflags;
    logic        a_valid, b_valid;
    logic [31:0] a_faddr, b_faddr, a_txn, b_txn, a_smax, b_smax;
    logic [1:0]  a_fsel, b_fsel;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_multi_monitor #(.AW(32), .DW(32), .NS(4), .MAXSTALL(4), .OPT_SLVERR(1), .OPT_APB4(1), .CW(32)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .i_clear(i_clear), .o_err_flags(a_flags), .o_err_valid(a_valid),
        .o_first_flags(a_fflags), .o_first_addr(a_faddr), .o_first_sel(a_fsel),
        .o_txn_count(a_txn), .o_stall_max(a_smax));

    apb_multi_monitor #(.AW(32), .DW(32), .NS(4), .MAXSTALL(0), .OPT_SLVERR(0), .OPT_APB4(0), .CW(32)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .i_clear(i_clear), .o_err_flags(b_flags), .o_err_valid(b_valid),
        .o_first_flags(b_fflags), .o_first_addr(b_faddr), .o_first_sel(b_fsel),
        .o_txn_count(b_txn), .o_stall_max(b_smax));

    wire [114:0] got_a = {a_flags, a_valid, a_fflags, a_faddr, a_fsel, a_txn, a_smax};
    wire [114:0] got_b = {b_flags, b_valid, b_fflags, b_faddr, b_fsel, b_txn, b_smax};

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  psel;
        logic        en;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [3:0]  rdy;
        logic [3:0]  err;
    } bus_t;

    typedef struct {
        bus_t        prev;
        int          stall;
        logic [7:0]  flags;
        logic [7:0]  ff;
        logic [31:0] fa;
        logic [1:0]  fs;
        longint      txn;
        longint      smax;
    } ms_t;

    ms_t ma, mb;

    function automatic ms_t ms_reset();
        ms_t m;
        m.prev  = '{psel: 4'h0, en: 1'b0, addr: 32'h0, wr: 1'b0, wdata: 32'h0,
                    strb: 4'h0, prot: 3'h0, rdy: 4'h0, err: 4'h0};
        m.stall = 0;
        m.flags = 8'h00;
        m.ff    = 8'h00;
        m.fa    = 32'h0;
        m.fs    = 2'h0;
        m.txn   = 0;
        m.smax  = 0;
        return m;
    endfunction

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic bus_t sample_bus();
        bus_t b;
        b.psel = PSEL;  b.en = PENABLE; b.addr = PADDR; b.wr = PWRITE; b.wdata = PWDATA;
        b.strb = PSTRB; b.prot = PPROT; b.rdy = PREADY; b.err = PSLVERR;
        return b;
    endfunction

    function automatic ms_t step(ms_t s, bus_t b, logic clr, int maxst, bit slv_ok, bit apb4);
        ms_t        n;
        logic [7:0] v;
        bit         sel, psel, rdy, err, pdone, mid, stalled, want_en;
        int         idx, pidx;
        n     = s;
        v     = 8'h00;
        sel   = (b.psel != 0);
        psel  = (s.prev.psel != 0);
        idx   = lowest(b.psel);
        pidx  = lowest(s.prev.psel);
        rdy   = b.rdy[idx];
        err   = b.err[idx];
        pdone = psel && s.prev.en && s.prev.rdy[pidx];
        mid   = psel && !pdone;
        stalled = sel && b.en && !rdy;

        v[0] = ($countones(b.psel) > 1);
        v[1] = mid && (!sel || idx != pidx);
        v[2] = sel && !psel && b.en;
        want_en = s.prev.en ? !s.prev.rdy[pidx] : 1'b1;
        v[3] = sel && psel && (b.en != want_en);
        v[4] = mid && (b.addr != s.prev.addr || b.wr != s.prev.wr || b.prot != s.prev.prot ||
                       (b.wr && (b.wdata != s.prev.wdata || b.strb != s.prev.strb)));
        v[6] = err && (!sel || !b.en || !rdy || !slv_ok);
        v[7] = apb4 && sel && !b.wr && (b.strb != 0);

        if (stalled) begin
            if (maxst != 0 && s.stall == maxst - 1) v[5] = 1'b1;
            n.stall = (maxst != 0 && s.stall >= maxst) ? maxst : s.stall + 1;
        end else begin
            n.stall = 0;
        end

        if (clr) begin
            n.flags = 8'h00; n.ff = 8'h00; n.fa = 32'h0; n.fs = 2'h0; n.txn = 0; n.smax = 0;
        end
        if (v != 0 && n.flags == 0) begin
            n.ff = v; n.fa = b.addr; n.fs = 2'(idx);
        end
        n.flags = n.flags | v;
        if (sel && b.en && rdy && n.txn < 64'hFFFF_FFFF) n.txn = n.txn + 1;
        if (!stalled && s.stall > n.smax) n.smax = s.stall;
        n.prev = b;
        return n;
    endfunction

    function automatic logic [114:0] exp_of(ms_t m);
        return {m.flags, |m.flags, m.ff, m.fa, m.fs, 32'(m.txn), 32'(m.smax)};
    endfunction

    always @(posedge PCLK) begin
        if (PRESET) begin
            ma <= ms_reset();
            mb <= ms_reset();
        end else begin
            ma <= step(ma, sample_bus(), i_clear, 4, 1'b1, 1'b1);
            mb <= step(mb, sample_bus(), i_clear, 0, 1'b0, 1'b0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic cyc(input logic [3:0] sel, input logic en, input logic [3:0] rdy, input logic [3:0] err);
        PSEL = sel; PENABLE = en; PREADY = rdy; PSLVERR = err;
        tick();
    endtask

    task automatic clear_pulse();
        i_clear = 1'b1;
        cyc(4'h0, 1'b0, 4'h0, 4'h0);
        i_clear = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        PRESET = 1'b1; i_clear = 1'b0; PADDR = 32'hDEAD_0000; PWRITE = 1'b0;
        PWDATA = 32'h0; PSTRB = 4'hF; PPROT = 3'h0;
        cyc(4'b0011, 1'b1, 4'h0, 4'hF);
        cyc(4'b0011, 1'b1, 4'h0, 4'hF);
        checks++; if (got_a !== '0) begin errors++; $display("FAIL reset_a got %h exp 0", got_a); end
        checks++; if (got_b !== '0) begin errors++; $display("FAIL reset_b got %h exp 0", got_b); end
        PRESET = 1'b0; PSTRB = 4'h0;
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (got_a !== '0) begin errors++; $display("FAIL idle_after_reset got %h exp 0", got_a); end
    endtask

    task automatic test_legal_write();
        PADDR = 32'h1000; PWRITE = 1'b1; PWDATA = 32'hCAFE_0001; PSTRB = 4'hF; PPROT = 3'h0;
        cyc(4'b0100, 1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) cyc(4'b0100, 1'b1, 4'h0, 4'h0);
        cyc(4'b0100, 1'b1, 4'b0100, 4'h0);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h00) begin errors++; $display("FAIL legal_flags got %h exp 00", a_flags); end
        checks++; if (a_txn !== 32'd1) begin errors++; $display("FAIL legal_txn got %0d exp 1", a_txn); end
        checks++; if (a_smax !== 32'd3) begin errors++; $display("FAIL legal_smax got %0d exp 3", a_smax); end
        checks++; if (got_b !== exp_of(mb)) begin errors++; $display("FAIL legal_model_b got %h exp %h", got_b, exp_of(mb)); end
    endtask

    task automatic test_timeout();
        clear_pulse();
        PADDR = 32'h40; PWRITE = 1'b0; PSTRB = 4'h0;
        cyc(4'b0010, 1'b0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b1, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h00) begin errors++; $display("FAIL timeout_early got %h exp 00", a_flags); end
        cyc(4'b0010, 1'b1, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h20) begin errors++; $display("FAIL timeout_hit got %h exp 20", a_flags); end
        for (int k = 0; k < 2; k++) cyc(4'b0010, 1'b1, 4'h0, 4'h0);
        cyc(4'b0010, 1'b1, 4'b0010, 4'h0);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_fflags !== 8'h20) begin errors++; $display("FAIL timeout_first got %h exp 20", a_fflags); end
        checks++; if (a_fsel !== 2'd1) begin errors++; $display("FAIL timeout_sel got %0d exp 1", a_fsel); end
        checks++; if (a_smax !== 32'd4) begin errors++; $display("FAIL timeout_smax got %0d exp 4", a_smax); end
        checks++; if (b_smax !== 32'd6) begin errors++; $display("FAIL nocap_smax got %0d exp 6", b_smax); end
        checks++; if (b_flags !== 8'h00) begin errors++; $display("FAIL nocap_flags got %h exp 00", b_flags); end
    endtask

    task automatic test_addr_change();
        clear_pulse();
        PADDR = 32'h20; PWRITE = 1'b1; PWDATA = 32'h55; PSTRB = 4'hF;
        cyc(4'b0001, 1'b0, 4'h0, 4'h0);
        cyc(4'b0001, 1'b1, 4'h0, 4'h0);
        PADDR = 32'h24;
        cyc(4'b0011, 1'b1, 4'h0, 4'h0);
        checks++; if (a_fflags !== 8'h11) begin errors++; $display("FAIL addr_first got %h exp 11", a_fflags); end
        checks++; if (a_faddr !== 32'h24) begin errors++; $display("FAIL addr_capture got %h exp 24", a_faddr); end
        cyc(4'b0001, 1'b1, 4'b0001, 4'h0);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h11) begin errors++; $display("FAIL addr_flags got %h exp 11", a_flags); end
        checks++; if (got_a !== exp_of(ma)) begin errors++; $display("FAIL addr_model_a got %h exp %h", got_a, exp_of(ma)); end
    endtask

    task automatic test_slverr();
        clear_pulse();
        PADDR = 32'h80; PWRITE = 1'b0; PSTRB = 4'h0;
        cyc(4'b0001, 1'b0, 4'h0, 4'b0001);
        checks++; if (a_flags !== 8'h40) begin errors++; $display("FAIL slverr_setup got %h exp 40", a_flags); end
        cyc(4'b0001, 1'b1, 4'b0001, 4'b0001);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h40) begin errors++; $display("FAIL slverr_done_flags got %h exp 40", a_flags); end
        checks++; if (a_txn !== 32'd1) begin errors++; $display("FAIL slverr_txn got %0d exp 1", a_txn); end
        checks++; if (got_b !== exp_of(mb)) begin errors++; $display("FAIL slverr_model_b got %h exp %h", got_b, exp_of(mb)); end
    endtask

    task automatic test_apb4();
        clear_pulse();
        PADDR = 32'hC0; PWRITE = 1'b0; PSTRB = 4'hF;
        cyc(4'b1000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h80) begin errors++; $display("FAIL apb4_on got %h exp 80", a_flags); end
        checks++; if (b_flags !== 8'h00) begin errors++; $display("FAIL apb4_off got %h exp 00", b_flags); end
        cyc(4'b1000, 1'b1, 4'b1000, 4'h0);
        PSTRB = 4'h0;
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_txn !== 32'd1) begin errors++; $display("FAIL apb4_txn got %0d exp 1", a_txn); end
    endtask

    task automatic test_back_to_back();
        clear_pulse();
        PADDR = 32'h100; PWRITE = 1'b1; PWDATA = 32'h1234; PSTRB = 4'h3;
        cyc(4'b1000, 1'b0, 4'h0, 4'h0);
        cyc(4'b1000, 1'b1, 4'b1000, 4'h0);
        PADDR = 32'h104; PWDATA = 32'h5678;
        cyc(4'b1000, 1'b0, 4'h0, 4'h0);
        cyc(4'b1000, 1'b1, 4'b1000, 4'h0);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h00) begin errors++; $display("FAIL b2b_flags got %h exp 00", a_flags); end
        checks++; if (a_txn !== 32'd2) begin errors++; $display("FAIL b2b_txn got %0d exp 2", a_txn); end
    endtask

    task automatic test_clear_and_reset();
        cyc(4'b0000, 1'b0, 4'h0, 4'b0001);
        PADDR = 32'h200; PWRITE = 1'b0; PSTRB = 4'h0;
        i_clear = 1'b1;
        cyc(4'b0100, 1'b1, 4'h0, 4'h0);
        i_clear = 1'b0;
        checks++; if (a_flags !== 8'h04) begin errors++; $display("FAIL clear_flags got %h exp 04", a_flags); end
        checks++; if (a_fflags !== 8'h04) begin errors++; $display("FAIL clear_first got %h exp 04", a_fflags); end
        checks++; if (a_txn !== 32'd0 || a_smax !== 32'd0) begin
            errors++; $display("FAIL clear_counters got txn %0d smax %0d exp 0 0", a_txn, a_smax);
        end
        PRESET = 1'b1;
        cyc(4'b0100, 1'b1, 4'h0, 4'h0);
        PRESET = 1'b0;
        checks++; if (got_a !== '0) begin errors++; $display("FAIL midreset got %h exp 0", got_a); end
        cyc(4'b0100, 1'b0, 4'h0, 4'h0);
        cyc(4'b0100, 1'b1, 4'b0100, 4'h0);
        cyc(4'b0000, 1'b0, 4'h0, 4'h0);
        checks++; if (a_flags !== 8'h00) begin errors++; $display("FAIL post_reset_flags got %h exp 00", a_flags); end
        checks++; if (a_txn !== 32'd1) begin errors++; $display("FAIL post_reset_txn got %0d exp 1", a_txn); end
    endtask

    task automatic test_random();
        int gs = 0;
        int s = 0;
        bit slow = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            PRESET  = ($urandom_range(0, 199) == 0);
            i_clear = ($urandom_range(0, 49) == 0);
            PSLVERR = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            PREADY  = 4'($urandom);
            if (gs == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    s = $urandom_range(0, 3);
                    slow = ($urandom_range(0, 3) == 0);
                    PSEL = 4'(1 << s); PENABLE = 1'b0;
                    PWRITE = 1'($urandom_range(0, 1));
                    PADDR  = 32'($urandom_range(0, 255)) << 2;
                    PWDATA = $urandom;
                    PSTRB  = PWRITE ? 4'($urandom) : 4'h0;
                    PPROT  = 3'($urandom);
                    gs = 1;
                end else begin
                    PSEL = 4'h0; PENABLE = 1'b0;
                end
            end else begin
                PENABLE = 1'b1;
                PREADY[s] = ($urandom_range(0, slow ? 5 : 1) == 0);
                gs = PREADY[s] ? 0 : 2;
            end
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 4))
                    0:       PSEL = PSEL ^ 4'(1 << $urandom_range(0, 3));
                    1:       PENABLE = ~PENABLE;
                    2:       PADDR = PADDR ^ 32'h4;
                    3:       PSTRB = 4'($urandom);
                    default: PWDATA = $urandom;
                endcase
            end
            if (PRESET) gs = 0;
            tick();
            checks++;
            if (got_a !== exp_of(ma)) begin
                errors++; $display("FAIL random_a cycle %0d got %h exp %h", c, got_a, exp_of(ma));
            end
            checks++;
            if (got_b !== exp_of(mb)) begin
                errors++; $display("FAIL random_b cycle %0d got %h exp %h", c, got_b, exp_of(mb));
            end
        end
        PRESET = 1'b0; i_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_write();
        test_timeout();
        test_addr_change();
        test_slverr();
        test_apb4();
        test_back_to_back();
        test_clear_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
